// File: rtl/exe_hazard_controller_if.sv
// Decode-to-execute hazard interface: decode/redirect inputs in, forwarding
// selects plus stall/flush/bubble controls out, and FSM debug visibility.
interface exe_hazard_controller_if #(
  parameter int REG_ADDR_W = 5
) ();
  logic                  i_DecValid;
  logic [REG_ADDR_W-1:0] i_DecRs1;
  logic [REG_ADDR_W-1:0] i_DecRs2;
  logic                  i_DecUsesRs1;
  logic                  i_DecUsesRs2;
  logic [REG_ADDR_W-1:0] i_DecRd;
  logic                  i_DecRegWrite;
  logic [1:0]            i_DecWbSrc;
  logic                  i_BranchTaken;
  logic [1:0]            o_ForwardOp1;
  logic [1:0]            o_ForwardOp2;
  logic                  o_StallFetch;
  logic                  o_StallDecode;
  logic                  o_FlushDecode;
  logic                  o_ExeBubble;
  logic                  o_Busy;
  // Debug view of the stall FSM: 1 while in STALL, plus the bubble counter.
  logic                  dbg_state;
  logic [1:0]            dbg_cnt;

  // Handshake: there is no valid/ready pair here. i_DecValid qualifies the
  // decode fields every cycle; the instruction is taken exactly in the cycles
  // where i_DecValid=1, o_StallDecode=0 and i_BranchTaken=0.
  modport master (
    output i_DecValid, i_DecRs1, i_DecRs2, i_DecUsesRs1, i_DecUsesRs2,
           i_DecRd, i_DecRegWrite, i_DecWbSrc, i_BranchTaken,
    input  o_ForwardOp1, o_ForwardOp2, o_StallFetch, o_StallDecode,
           o_FlushDecode, o_ExeBubble, o_Busy, dbg_state, dbg_cnt
  );

  modport slave (
    input  i_DecValid, i_DecRs1, i_DecRs2, i_DecUsesRs1, i_DecUsesRs2,
           i_DecRd, i_DecRegWrite, i_DecWbSrc, i_BranchTaken,
    output o_ForwardOp1, o_ForwardOp2, o_StallFetch, o_StallDecode,
           o_FlushDecode, o_ExeBubble, o_Busy, dbg_state, dbg_cnt
  );
endinterface

// File: rtl/exe_hazard_controller.sv
// Execute-stage sequencer: tracks EXE/MEM writers, registers forwarding
// selects, runs the load-use stall FSM and squashes on EXE redirects.
module exe_hazard_controller #(
  parameter int REG_ADDR_W  = 5,
  parameter int LOAD_STALLS = 1
) (
  input logic                     i_Clk,
  input logic                     i_Rst,
  exe_hazard_controller_if.slave  hz
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  localparam logic [1:0] WB_LOAD     = 2'b01;
  localparam logic [1:0] WB_LDI      = 2'b10;
  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_MEM_ALU = 2'b01;
  localparam logic [1:0] FWD_WB      = 2'b10;
  localparam logic [1:0] FWD_MEM_LDI = 2'b11;
  localparam logic [1:0] STALL_INIT  = 2'(LOAD_STALLS - 1);

  state_t                state, state_next;
  logic [1:0]            cnt, cnt_next;
  logic                  exe_valid;
  logic [REG_ADDR_W-1:0] exe_rd;
  logic [1:0]            exe_wbsrc;
  logic                  mem_valid;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [1:0]            fwd1, fwd2;
  logic                  exe_bubble;

  logic rs1_exe, rs2_exe, rs1_mem, rs2_mem;
  logic load_use, stall, advance;
  logic [1:0] fwd1_next, fwd2_next;

  // EXE producer wins; its value comes from MEM next cycle (ALU result or
  // LDI immediate). Reserved wbsrc behaves as ALU.
  function automatic logic [1:0] fwd_sel(input logic hit_exe, input logic hit_mem,
                                         input logic [1:0] wbsrc);
    if (hit_exe)      fwd_sel = (wbsrc == WB_LDI) ? FWD_MEM_LDI : FWD_MEM_ALU;
    else if (hit_mem) fwd_sel = FWD_WB;
    else              fwd_sel = FWD_RF;
  endfunction

  always_comb begin
    rs1_exe   = hz.i_DecUsesRs1 & exe_valid & (exe_rd == hz.i_DecRs1);
    rs2_exe   = hz.i_DecUsesRs2 & exe_valid & (exe_rd == hz.i_DecRs2);
    rs1_mem   = hz.i_DecUsesRs1 & mem_valid & (mem_rd == hz.i_DecRs1);
    rs2_mem   = hz.i_DecUsesRs2 & mem_valid & (mem_rd == hz.i_DecRs2);
    load_use  = hz.i_DecValid & (rs1_exe | rs2_exe) & (exe_wbsrc == WB_LOAD);
    fwd1_next = fwd_sel(rs1_exe, rs1_mem, exe_wbsrc);
    fwd2_next = fwd_sel(rs2_exe, rs2_mem, exe_wbsrc);
  end

  // Redirect overrides everything, including an in-progress stall.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall      = 1'b0;
    if (hz.i_BranchTaken) begin
      state_next = RUN;
      cnt_next   = 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (load_use) begin
            stall = 1'b1;
            if (LOAD_STALLS > 1) begin
              state_next = STALL;
              cnt_next   = STALL_INIT;
            end
          end
        end
        STALL: begin
          stall = 1'b1;
          if (cnt <= 2'd1) begin
            state_next = RUN;
            cnt_next   = 2'd0;
          end else begin
            cnt_next = cnt - 2'd1;
          end
        end
        default: begin
          state_next = RUN;
          cnt_next   = 2'd0;
        end
      endcase
    end
    advance = hz.i_DecValid & ~stall & ~hz.i_BranchTaken;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state      <= RUN;
      cnt        <= 2'd0;
      exe_valid  <= 1'b0;
      exe_rd     <= '0;
      exe_wbsrc  <= 2'b00;
      mem_valid  <= 1'b0;
      mem_rd     <= '0;
      fwd1       <= FWD_RF;
      fwd2       <= FWD_RF;
      exe_bubble <= 1'b1;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      mem_valid  <= exe_valid;
      mem_rd     <= exe_rd;
      exe_valid  <= advance & hz.i_DecRegWrite;
      exe_rd     <= hz.i_DecRd;
      exe_wbsrc  <= hz.i_DecWbSrc;
      fwd1       <= advance ? fwd1_next : FWD_RF;
      fwd2       <= advance ? fwd2_next : FWD_RF;
      exe_bubble <= ~advance;
    end
  end

  assign hz.o_ForwardOp1  = fwd1;
  assign hz.o_ForwardOp2  = fwd2;
  assign hz.o_StallFetch  = stall;
  assign hz.o_StallDecode = stall;
  assign hz.o_FlushDecode = hz.i_BranchTaken;
  assign hz.o_ExeBubble   = exe_bubble;
  assign hz.o_Busy        = (state != RUN);
  assign hz.dbg_state     = (state == STALL);
  assign hz.dbg_cnt       = cnt;

endmodule
